// File: rtl/booth_multiplier_pkg.sv
// Shared widths and FSM encoding for the sequential Booth multiplier.
// Latency: none here; no backpressure, declarations only.
package booth_multiplier_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full32BitAdder.sv
// 32-bit add/subtract with carry-out and signed overflow flag.
// Latency: combinational; no backpressure.
module full32BitAdder (
    output logic [31:0] sum,
    output logic        carryout,
    output logic        overflow,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        subtract
);

    logic [31:0] b_eff;

    assign b_eff             = b ^ {32{subtract}};
    assign {carryout, sum}   = {1'b0, a} + {1'b0, b_eff} + {32'b0, subtract};
    // Signed overflow: operands agree in sign, result does not.
    assign overflow          = (a[31] == b_eff[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/booth_multiplier.sv
// Signed 32x32->64 radix-2 Booth multiplier, one iteration per clock.
// Latency: done pulses 33 cycles after the start edge; start is ignored while busy (no backpressure).
module booth_multiplier
    import booth_multiplier_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               q_1;
    logic [CNT_W-1:0]   count;

    logic               load;
    logic               step;
    logic               last;

    logic [WIDTH-1:0]   sum;
    logic               unused_carry;
    logic               overflow;
    logic               subtract;
    logic               use_sum;
    logic [WIDTH-1:0]   r;
    logic               s;
    logic [WIDTH-1:0]   a_next;
    logic [WIDTH-1:0]   q_next;

    full32BitAdder u_adder (
        .sum      (sum),
        .carryout (unused_carry),
        .overflow (overflow),
        .a        (a_reg),
        .b        (m_reg),
        .subtract (subtract)
    );

    always_comb begin
        subtract = 1'b0;
        use_sum  = 1'b0;
        case ({q_reg[0], q_1})
            2'b10: begin subtract = 1'b1; use_sum = 1'b1; end
            2'b01: begin subtract = 1'b0; use_sum = 1'b1; end
            default: ;
        endcase
        r = use_sum ? sum : a_reg;
        // True sign of the add/sub result, so M = -2^31 does not lose its sign.
        s = use_sum ? (sum[WIDTH-1] ^ overflow) : a_reg[WIDTH-1];
        a_next = {s, r[WIDTH-1:1]};
        q_next = {r[0], q_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (load) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            q_1   <= 1'b0;
            count <= '0;
        end else if (step) begin
            a_reg <= a_next;
            q_reg <= q_next;
            q_1   <= q_reg[0];
            count <= count + CNT_W'(1);
            if (last) begin
                product <= {a_next, q_next};
            end
        end
    end

endmodule
